// File: rtl/caliptra_prim_packer_fifo_buf_pkg.sv
// Shared types and helpers for the packer FIFO buffer: front-end mode selection
// and byte-mask legality.
package caliptra_prim_packer_fifo_buf_pkg;

    typedef enum logic [1:0] {
        MODE_PACK   = 2'd0,
        MODE_UNPACK = 2'd1,
        MODE_PASS   = 2'd2
    } mode_e;

    function automatic mode_e get_mode(input int in_w, input int out_w);
        if (in_w < out_w) return MODE_PACK;
        if (in_w > out_w) return MODE_UNPACK;
        return MODE_PASS;
    endfunction

    // Mask must be contiguous from bit 0, and may only be partial on the last beat.
    function automatic logic mask_legal(input logic [63:0] mask, input logic last, input int nbytes);
        logic [63:0] all_ones;
        all_ones = (64'd1 << nbytes) - 64'd1;
        return ((mask & (mask + 64'd1)) == 64'd0) && (last || (mask == all_ones));
    endfunction

endpackage

// File: rtl/caliptra_prim_packer_fifo_buf_if.sv
// Write/read stream bundle of the packer FIFO buffer; slave is the buffer's view.
interface caliptra_prim_packer_fifo_buf_if
    import caliptra_prim_packer_fifo_buf_pkg::*;
#(
    parameter int InW   = 32,
    parameter int OutW  = 8,
    parameter int Depth = 2
);
    logic                         wvalid_i;
    logic [InW-1:0]               wdata_i;
    logic [InW/8-1:0]             wmask_i;
    logic                         wlast_i;
    logic                         wready_o;
    logic                         rvalid_o;
    logic [OutW-1:0]              rdata_o;
    logic [OutW/8-1:0]            rmask_o;
    logic                         rlast_o;
    logic                         rready_i;
    logic [$clog2(Depth+1)-1:0]   depth_o;
    logic                         idle_o;

    modport slave (
        input  wvalid_i, wdata_i, wmask_i, wlast_i, rready_i,
        output wready_o, rvalid_o, rdata_o, rmask_o, rlast_o, depth_o, idle_o
    );

    modport master (
        output wvalid_i, wdata_i, wmask_i, wlast_i, rready_i,
        input  wready_o, rvalid_o, rdata_o, rmask_o, rlast_o, depth_o, idle_o
    );
endinterface

// File: rtl/caliptra_prim_packer_fifo_buf_fifo_sync.sv
// Synchronous FIFO with occupancy count; optional pass-through when empty.
module caliptra_prim_fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 2,
    parameter bit Pass  = 1'b0,
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             wvalid_i,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic [CntW-1:0]  depth_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             empty, pass_thru, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign depth_o = cnt_q;

    if (Pass) begin : gen_pass_thru
        assign pass_thru = empty && wvalid_i && rready_i;
        assign rvalid_o  = !empty || wvalid_i;
        assign rdata_o   = empty ? wdata_i : mem_q[rptr_q];
    end else begin : gen_registered
        assign pass_thru = 1'b0;
        assign rvalid_o  = !empty;
        assign rdata_o   = mem_q[rptr_q];
    end

    assign do_push = wvalid_i && !full_o && !pass_thru;
    assign do_pop  = rready_i && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni || clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end
endmodule

// File: rtl/caliptra_prim_packer_fifo_buf.sv
// Width converter (pack / unpack / pass) feeding an output FIFO of {data, mask, last}
// entries; partial final words are flushed rather than held.
module caliptra_prim_packer_fifo_buf
    import caliptra_prim_packer_fifo_buf_pkg::*;
#(
    parameter int InW         = 32,
    parameter int OutW        = 8,
    parameter int Depth       = 2,
    parameter bit ClearOnRead = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    caliptra_prim_packer_fifo_buf_if.slave bus
);
    localparam int    InB  = InW / 8;
    localparam int    OutB = OutW / 8;
    localparam int    EntW = OutW + OutB + 1;
    localparam int    CntW = $clog2(Depth + 1);
    localparam mode_e Mode = get_mode(InW, OutW);

    logic            clr_q;
    logic            wready, push, push_last, fe_idle;
    logic [OutW-1:0] push_data;
    logic [OutB-1:0] push_mask;
    logic            fifo_rvalid, fifo_full, rvalid, pop;
    logic [EntW-1:0] fifo_rdata, ent;
    logic [CntW-1:0] depth;

    // Comes out of reset in the cleared state so the first cycle is quiet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) clr_q <= 1'b1;
        else         clr_q <= clr_i;
    end

    if (Mode == MODE_PACK) begin : gen_pack
        localparam int R  = OutW / InW;
        localparam int CW = $clog2(R);
        logic [CW-1:0]   cnt_q;
        logic [OutW-1:0] acc_d_q, word_d;
        logic [OutB-1:0] acc_m_q, word_m;
        logic            accept, done;

        assign wready = !clr_q && !fifo_full;
        assign accept = bus.wvalid_i && wready;
        // Slices at and above cnt_q are always zero, so OR-ing in the new beat is enough.
        assign word_d = acc_d_q | (OutW'(bus.wdata_i) << (cnt_q * InW));
        assign word_m = acc_m_q | (OutB'(bus.wmask_i) << (cnt_q * InB));
        assign done   = (cnt_q == CW'(R - 1)) || bus.wlast_i;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni || clr_q) begin
                cnt_q   <= '0;
                acc_d_q <= '0;
                acc_m_q <= '0;
            end else if (accept) begin
                if (done) begin
                    cnt_q   <= '0;
                    acc_d_q <= '0;
                    acc_m_q <= '0;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                    acc_d_q <= word_d;
                    acc_m_q <= word_m;
                end
            end
        end

        assign push      = accept && done;
        assign push_data = word_d;
        assign push_mask = word_m;
        assign push_last = bus.wlast_i;
        assign fe_idle   = (cnt_q == '0);
    end else if (Mode == MODE_UNPACK) begin : gen_unpack
        localparam int R  = InW / OutW;
        localparam int CW = $clog2(R);
        logic            stg_v_q, stg_last_q, accept;
        logic [InW-1:0]  stg_d_q;
        logic [InB-1:0]  stg_m_q;
        logic [CW-1:0]   ptr_q, end_q, end_d;

        assign wready = !clr_q && !stg_v_q;
        assign accept = bus.wvalid_i && wready;

        // Last chunk with any valid byte; an all-zero mask still emits chunk 0.
        always_comb begin
            end_d = '0;
            for (int i = 0; i < R; i++) begin
                if (|bus.wmask_i[i*OutB +: OutB]) end_d = CW'(i);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni || clr_q) begin
                stg_v_q    <= 1'b0;
                stg_last_q <= 1'b0;
                stg_d_q    <= '0;
                stg_m_q    <= '0;
                ptr_q      <= '0;
                end_q      <= '0;
            end else if (accept) begin
                stg_v_q    <= 1'b1;
                stg_last_q <= bus.wlast_i;
                stg_d_q    <= bus.wdata_i;
                stg_m_q    <= bus.wmask_i;
                ptr_q      <= '0;
                end_q      <= end_d;
            end else if (push) begin
                if (ptr_q == end_q) stg_v_q <= 1'b0;
                else                ptr_q   <= ptr_q + 1'b1;
            end
        end

        assign push      = stg_v_q && !clr_q && !fifo_full;
        assign push_data = stg_d_q[ptr_q*OutW +: OutW];
        assign push_mask = stg_m_q[ptr_q*OutB +: OutB];
        assign push_last = stg_last_q && (ptr_q == end_q);
        assign fe_idle   = !stg_v_q;
    end else begin : gen_pass
        assign wready    = !clr_q && !fifo_full;
        assign push      = bus.wvalid_i && wready;
        assign push_data = bus.wdata_i;
        assign push_mask = bus.wmask_i;
        assign push_last = bus.wlast_i;
        assign fe_idle   = 1'b1;
    end

    caliptra_prim_fifo_sync #(
        .Width (EntW),
        .Depth (Depth),
        .Pass  (1'b0)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr_q),
        .wvalid_i (push),
        .wdata_i  ({push_data, push_mask, push_last}),
        .rvalid_o (fifo_rvalid),
        .rready_i (pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .depth_o  (depth)
    );

    assign rvalid = fifo_rvalid && !clr_q;
    assign pop    = rvalid && bus.rready_i;
    assign ent    = (ClearOnRead && !rvalid) ? '0 : fifo_rdata;

    assign bus.wready_o = wready;
    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = ent[EntW-1 -: OutW];
    assign bus.rmask_o  = ent[OutB:1];
    assign bus.rlast_o  = ent[0];
    assign bus.depth_o  = depth;
    assign bus.idle_o   = fe_idle && (depth == '0);

    a_rvalid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid && !bus.rready_i && !clr_i |=> rvalid);
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid && !bus.rready_i && !clr_i |=> $stable(ent));
    a_wmask_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.wvalid_i && wready |-> mask_legal(64'(bus.wmask_i), bus.wlast_i, InB));
    a_depth_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        depth <= CntW'(Depth));
endmodule

// File: tb/tb_caliptra_prim_packer_fifo_buf.sv
// Directed bench: table-driven pack 8->32 vectors plus hand sequences for
// backpressure, clear, unpack 32->8, reset and 32->32 pass.
module tb_caliptra_prim_packer_fifo_buf;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic pk_clr = 1'b0, up_clr = 1'b0, ps_clr = 1'b0;
    int   n_total = 0, n_pass = 0;

    always #5 clk_i = ~clk_i;

    caliptra_prim_packer_fifo_buf_if #(.InW(8),  .OutW(32), .Depth(2)) pk_if ();
    caliptra_prim_packer_fifo_buf_if #(.InW(32), .OutW(8),  .Depth(2)) up_if ();
    caliptra_prim_packer_fifo_buf_if #(.InW(32), .OutW(32), .Depth(2)) ps_if ();

    caliptra_prim_packer_fifo_buf #(.InW(8), .OutW(32), .Depth(2), .ClearOnRead(1'b1)) u_pk (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(pk_clr), .bus(pk_if.slave));
    caliptra_prim_packer_fifo_buf #(.InW(32), .OutW(8), .Depth(2), .ClearOnRead(1'b1)) u_up (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(up_clr), .bus(up_if.slave));
    caliptra_prim_packer_fifo_buf #(.InW(32), .OutW(32), .Depth(2), .ClearOnRead(1'b1)) u_ps (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(ps_clr), .bus(ps_if.slave));

    typedef struct {
        logic        wv;
        logic [7:0]  wd;
        logic        wl;
        logic        rr;
        logic        ew;
        logic        erv;
        logic [31:0] ed;
        logic [3:0]  em;
        logic        el;
        logic [1:0]  edp;
    } vec_t;

    vec_t vecs [11];

    logic [7:0] got_d [8];
    logic       got_m [8];
    logic       got_l [8];
    int         up_low, up_n, bp_n;
    logic       bp_acc;

    logic [7:0] e3_d [3] = '{8'h11, 8'h22, 8'h33};
    logic       e3_l [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] e4_d [4] = '{8'h04, 8'h03, 8'h02, 8'h01};

    function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic wl, input logic rr,
                                input logic ew, input logic erv, input logic [31:0] ed,
                                input logic [3:0] em, input logic el, input logic [1:0] edp);
        vec_t v;
        v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr;
        v.ew = ew; v.erv = erv; v.ed = ed; v.em = em; v.el = el; v.edp = edp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic up_run(input logic [31:0] d, input logic [3:0] m, input logic l);
        for (int k = 0; k < 8; k++) begin
            got_d[k] = 8'h0; got_m[k] = 1'b0; got_l[k] = 1'b0;
        end
        up_if.wvalid_i = 1'b1;
        up_if.wdata_i  = d;
        up_if.wmask_i  = m;
        up_if.wlast_i  = l;
        up_if.rready_i = 1'b1;
        @(negedge clk_i);
        chk("up.wready_pre", 64'(up_if.wready_o), 64'd1);
        step();
        up_if.wvalid_i = 1'b0;
        up_if.wlast_i  = 1'b0;
        up_low = 0;
        up_n   = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (!up_if.wready_o) up_low++;
            if (up_if.rvalid_o && up_n < 8) begin
                got_d[up_n] = up_if.rdata_o;
                got_m[up_n] = up_if.rmask_o[0];
                got_l[up_n] = up_if.rlast_o;
                up_n++;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pk_if.wvalid_i = 1'b0; pk_if.wdata_i = '0; pk_if.wmask_i = '0; pk_if.wlast_i = 1'b0; pk_if.rready_i = 1'b0;
        up_if.wvalid_i = 1'b0; up_if.wdata_i = '0; up_if.wmask_i = '0; up_if.wlast_i = 1'b0; up_if.rready_i = 1'b0;
        ps_if.wvalid_i = 1'b0; ps_if.wdata_i = '0; ps_if.wmask_i = '0; ps_if.wlast_i = 1'b0; ps_if.rready_i = 1'b0;

        //           wv    wd     wl    rr    ew    erv   ed            em    el    depth
        vecs[0]  = mk(1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 2'd0);
        vecs[1]  = mk(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 2'd0);
        vecs[2]  = mk(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 2'd0);
        vecs[3]  = mk(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 2'd0);
        vecs[4]  = mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 2'd1);
        vecs[5]  = mk(1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 2'd0);
        vecs[6]  = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 2'd1);
        vecs[7]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 2'd2);
        vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 4'h3, 1'b1, 2'd2);
        vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000001, 4'h1, 1'b1, 2'd1);
        vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 2'd0);

        // Reset, then the quiet first cycle while the clear flop is still set.
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst.pk.wready", 64'(pk_if.wready_o), 64'd0);
        chk("rst.pk.rvalid", 64'(pk_if.rvalid_o), 64'd0);
        chk("rst.pk.rdata",  64'(pk_if.rdata_o),  64'd0);
        chk("rst.pk.rmask",  64'(pk_if.rmask_o),  64'd0);
        chk("rst.pk.rlast",  64'(pk_if.rlast_o),  64'd0);
        chk("rst.pk.depth",  64'(pk_if.depth_o),  64'd0);
        chk("rst.pk.idle",   64'(pk_if.idle_o),   64'd1);
        chk("rst.up.wready", 64'(up_if.wready_o), 64'd0);
        chk("rst.up.idle",   64'(up_if.idle_o),   64'd1);
        chk("rst.ps.wready", 64'(ps_if.wready_o), 64'd0);
        chk("rst.ps.rvalid", 64'(ps_if.rvalid_o), 64'd0);
        step();

        for (int i = 0; i < 11; i++) begin
            pk_if.wvalid_i = vecs[i].wv;
            pk_if.wdata_i  = vecs[i].wd;
            pk_if.wmask_i  = vecs[i].wv;
            pk_if.wlast_i  = vecs[i].wl;
            pk_if.rready_i = vecs[i].rr;
            @(negedge clk_i);
            chk($sformatf("pk_vec%0d.wready", i), 64'(pk_if.wready_o), 64'(vecs[i].ew));
            chk($sformatf("pk_vec%0d.rvalid", i), 64'(pk_if.rvalid_o), 64'(vecs[i].erv));
            chk($sformatf("pk_vec%0d.rdata",  i), 64'(pk_if.rdata_o),  64'(vecs[i].ed));
            chk($sformatf("pk_vec%0d.rmask",  i), 64'(pk_if.rmask_o),  64'(vecs[i].em));
            chk($sformatf("pk_vec%0d.rlast",  i), 64'(pk_if.rlast_o),  64'(vecs[i].el));
            chk($sformatf("pk_vec%0d.depth",  i), 64'(pk_if.depth_o),  64'(vecs[i].edp));
            step();
        end

        // Backpressure: stream beats 1,2,3,... with rready low until wready drops.
        pk_if.rready_i = 1'b0;
        pk_if.wlast_i  = 1'b0;
        pk_if.wmask_i  = 1'b1;
        pk_if.wvalid_i = 1'b1;
        bp_n = 0;
        pk_if.wdata_i = 8'd1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            bp_acc = pk_if.wready_o;
            step();
            if (bp_acc) bp_n++;
            pk_if.wdata_i = 8'(bp_n + 1);
        end
        pk_if.wvalid_i = 1'b0;
        @(negedge clk_i);
        chk("bp.beats",  64'(bp_n),             64'd8);
        chk("bp.depth",  64'(pk_if.depth_o),    64'd2);
        chk("bp.wready", 64'(pk_if.wready_o),   64'd0);
        chk("bp.rvalid", 64'(pk_if.rvalid_o),   64'd1);
        chk("bp.rdata",  64'(pk_if.rdata_o),    64'h04030201);
        chk("bp.rmask",  64'(pk_if.rmask_o),    64'hF);
        chk("bp.rlast",  64'(pk_if.rlast_o),    64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk_i);
            chk($sformatf("bp.hold%0d", c), 64'(pk_if.rdata_o), 64'h04030201);
        end
        step();
        pk_if.rready_i = 1'b1;
        step();
        @(negedge clk_i);
        chk("bp.word2",  64'(pk_if.rdata_o),  64'h08070605);
        chk("bp.depth1", 64'(pk_if.depth_o),  64'd1);
        step();
        @(negedge clk_i);
        chk("bp.drained", 64'(pk_if.rvalid_o), 64'd0);
        pk_if.rready_i = 1'b0;

        // Clear after two of four beats: no output, one quiet cycle, clean restart.
        step();
        pk_if.wvalid_i = 1'b1;
        pk_if.wdata_i  = 8'h55;
        step();
        pk_if.wdata_i  = 8'h66;
        step();
        pk_if.wvalid_i = 1'b0;
        pk_clr = 1'b1;
        step();
        pk_clr = 1'b0;
        @(negedge clk_i);
        chk("clr.wready_low", 64'(pk_if.wready_o), 64'd0);
        chk("clr.rvalid_low", 64'(pk_if.rvalid_o), 64'd0);
        chk("clr.busy",       64'(pk_if.idle_o),   64'd0);
        step();
        @(negedge clk_i);
        chk("clr.wready_back", 64'(pk_if.wready_o), 64'd1);
        chk("clr.depth",       64'(pk_if.depth_o),  64'd0);
        chk("clr.idle",        64'(pk_if.idle_o),   64'd1);
        chk("clr.rvalid",      64'(pk_if.rvalid_o), 64'd0);
        step();
        pk_if.wvalid_i = 1'b1;
        pk_if.wdata_i  = 8'h01;
        step();
        pk_if.wdata_i  = 8'h02;
        pk_if.wlast_i  = 1'b1;
        step();
        pk_if.wvalid_i = 1'b0;
        pk_if.wlast_i  = 1'b0;
        @(negedge clk_i);
        chk("clr.next.rvalid", 64'(pk_if.rvalid_o), 64'd1);
        chk("clr.next.rdata",  64'(pk_if.rdata_o),  64'h00000201);
        chk("clr.next.rmask",  64'(pk_if.rmask_o),  64'h3);
        chk("clr.next.rlast",  64'(pk_if.rlast_o),  64'd1);
        pk_if.rready_i = 1'b1;
        step();
        pk_if.rready_i = 1'b0;

        // Unpack 32->8 with a three-byte final word.
        up_run(32'h44332211, 4'h7, 1'b1);
        chk("up3.wready_low", 64'(up_low), 64'd3);
        chk("up3.count",      64'(up_n),   64'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("up3.data%0d", k), 64'(got_d[k]), 64'(e3_d[k]));
            chk($sformatf("up3.mask%0d", k), 64'(got_m[k]), 64'd1);
            chk($sformatf("up3.last%0d", k), 64'(got_l[k]), 64'(e3_l[k]));
        end

        // Full word, not last: all four chunks, none flagged last.
        up_run(32'h01020304, 4'hF, 1'b0);
        chk("up4.wready_low", 64'(up_low), 64'd4);
        chk("up4.count",      64'(up_n),   64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("up4.data%0d", k), 64'(got_d[k]), 64'(e4_d[k]));
            chk($sformatf("up4.last%0d", k), 64'(got_l[k]), 64'd0);
        end

        // Empty last word: a single zero-mask chunk carrying last.
        up_run(32'h000000AB, 4'h0, 1'b1);
        chk("up0.count", 64'(up_n),     64'd1);
        chk("up0.data",  64'(got_d[0]), 64'hAB);
        chk("up0.mask",  64'(got_m[0]), 64'd0);
        chk("up0.last",  64'(got_l[0]), 64'd1);
        chk("up0.idle",  64'(up_if.idle_o), 64'd1);

        // Reset in the middle of an unpack, then a pass-through beat.
        up_if.rready_i = 1'b0;
        up_if.wvalid_i = 1'b1;
        up_if.wdata_i  = 32'hCAFEF00D;
        up_if.wmask_i  = 4'hF;
        up_if.wlast_i  = 1'b0;
        step();
        up_if.wvalid_i = 1'b0;
        step();
        @(negedge clk_i);
        chk("rmid.pre.depth", 64'(up_if.depth_o), 64'd1);
        chk("rmid.pre.idle",  64'(up_if.idle_o),  64'd0);
        rst_ni = 1'b0;
        #1;
        chk("rmid.rvalid", 64'(up_if.rvalid_o), 64'd0);
        chk("rmid.depth",  64'(up_if.depth_o),  64'd0);
        chk("rmid.idle",   64'(up_if.idle_o),   64'd1);
        chk("rmid.wready", 64'(up_if.wready_o), 64'd0);
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rmid.ps.wready_q", 64'(ps_if.wready_o), 64'd0);
        step();
        ps_if.wvalid_i = 1'b1;
        ps_if.wdata_i  = 32'hDEADBEEF;
        ps_if.wmask_i  = 4'hF;
        ps_if.wlast_i  = 1'b1;
        ps_if.rready_i = 1'b1;
        @(negedge clk_i);
        chk("ps.wready", 64'(ps_if.wready_o), 64'd1);
        chk("ps.idle0",  64'(ps_if.idle_o),   64'd1);
        step();
        ps_if.wvalid_i = 1'b0;
        ps_if.wlast_i  = 1'b0;
        @(negedge clk_i);
        chk("ps.rvalid", 64'(ps_if.rvalid_o), 64'd1);
        chk("ps.rdata",  64'(ps_if.rdata_o),  64'hDEADBEEF);
        chk("ps.rmask",  64'(ps_if.rmask_o),  64'hF);
        chk("ps.rlast",  64'(ps_if.rlast_o),  64'd1);
        chk("ps.busy",   64'(ps_if.idle_o),   64'd0);
        step();
        @(negedge clk_i);
        chk("ps.rvalid_after", 64'(ps_if.rvalid_o), 64'd0);
        chk("ps.rdata_clear",  64'(ps_if.rdata_o),  64'd0);
        chk("ps.idle1",        64'(ps_if.idle_o),   64'd1);
        chk("up.idle_after",   64'(up_if.idle_o),   64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
